// File: rtl/tl_pkg.sv
// Shared types and defaults for the two-lane phase scheduler: phase encoding,
// lamp bundle, counter widths and default timing.
package tl_pkg;

  localparam int SEC_W = 8;
  localparam int MS_W  = 4;

  localparam int DEF_TICK_DIV    = 6;
  localparam int DEF_A_MIN_GREEN = 20;
  localparam int DEF_B_MIN_GREEN = 5;
  localparam int DEF_B_MAX_GREEN = 15;
  localparam int DEF_AMBER_T     = 3;
  localparam int DEF_ALL_RED_T   = 1;
  localparam int DEF_PED_T       = 4;

  typedef enum logic [2:0] {
    A_GREEN  = 3'd0,
    A_AMBER  = 3'd1,
    RED_AB   = 3'd2,
    B_GREEN  = 3'd3,
    B_AMBER  = 3'd4,
    RED_BA   = 3'd5,
    PED_WALK = 3'd6
  } phase_e;

  typedef struct packed {
    logic red_a;
    logic amber_a;
    logic green_a;
    logic red_b;
    logic amber_b;
    logic green_b;
  } lamp_t;

  // Unlisted phases (clearances, walk, illegal codes) fall back to all-red.
  function automatic lamp_t lamp_decode(input phase_e ph);
    lamp_t l;
    l = '0;
    case (ph)
      A_GREEN: begin l.green_a = 1'b1; l.red_b = 1'b1; end
      A_AMBER: begin l.amber_a = 1'b1; l.red_b = 1'b1; end
      B_GREEN: begin l.green_b = 1'b1; l.red_a = 1'b1; end
      B_AMBER: begin l.amber_b = 1'b1; l.red_a = 1'b1; end
      default: begin l.red_a   = 1'b1; l.red_b = 1'b1; end
    endcase
    return l;
  endfunction

endpackage

// File: rtl/tl_tick_gen.sv
// Prescaler: counts 0..TICK_DIV-1 every clock and flags the last count as the
// second tick. clr is a synchronous clear driven by the scheduler reset.
module tl_tick_gen
  import tl_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEF_TICK_DIV
) (
  input  logic            clk,
  input  logic            clr,
  output logic [MS_W-1:0] mili_sec_counter_val,
  output logic            sec_tick
);

  localparam logic [MS_W-1:0] LAST = MS_W'(TICK_DIV - 1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the reset here is synchronous, sampled on the edge.
  always_ff @(posedge clk) begin
    if (clr)
      mili_sec_counter_val <= '0;
    else if (mili_sec_counter_val == LAST)
      mili_sec_counter_val <= '0;
    else
      mili_sec_counter_val <= mili_sec_counter_val + 1'b1;
  end

  assign sec_tick = (mili_sec_counter_val == LAST);

endmodule

// File: rtl/tl_phase_scheduler.sv
// Two-lane junction phase sequencer with amber/all-red bracketing and
// demand-driven green sharing. Optional pedestrian phase: TL_PED_PHASE_EN.
module tl_phase_scheduler
  import tl_pkg::*;
#(
  parameter int unsigned TICK_DIV    = DEF_TICK_DIV,
  parameter int unsigned A_MIN_GREEN = DEF_A_MIN_GREEN,
  parameter int unsigned B_MIN_GREEN = DEF_B_MIN_GREEN,
  parameter int unsigned B_MAX_GREEN = DEF_B_MAX_GREEN,
  parameter int unsigned AMBER_T     = DEF_AMBER_T,
`ifdef TL_PED_PHASE_EN
  parameter int unsigned PED_T       = DEF_PED_T,
`endif
  parameter int unsigned ALL_RED_T   = DEF_ALL_RED_T
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             traffic_B,
`ifdef TL_PED_PHASE_EN
  input  logic             ped_req,
  output logic             walk_light,
`endif
  output logic             red_light_A,
  output logic             amber_light_A,
  output logic             green_light_A,
  output logic             red_light_B,
  output logic             amber_light_B,
  output logic             green_light_B,
  output logic [SEC_W-1:0] sec_counter_val,
  output logic [MS_W-1:0]  mili_sec_counter_val,
  output logic [2:0]       phase_o
);

  localparam logic [SEC_W-1:0] A_MIN = SEC_W'(A_MIN_GREEN);
  localparam logic [SEC_W-1:0] B_MIN = SEC_W'(B_MIN_GREEN);
  localparam logic [SEC_W-1:0] B_MAX = SEC_W'(B_MAX_GREEN);
  localparam logic [SEC_W-1:0] AMB   = SEC_W'(AMBER_T);
  localparam logic [SEC_W-1:0] ALLR  = SEC_W'(ALL_RED_T);
`ifdef TL_PED_PHASE_EN
  localparam logic [SEC_W-1:0] PED   = SEC_W'(PED_T);
`endif

  phase_e           phase_q, phase_d, target;
  logic [SEC_W-1:0] sec_q, sec_d, sec_n;
  logic             sec_tick, leave;
  lamp_t            lamps;

`ifdef TL_PED_PHASE_EN
  phase_e resume_q, resume_d;
  logic   pend_q, enter_walk;
`endif

  tl_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk                  (clk),
    .clr                  (rst),
    .mili_sec_counter_val (mili_sec_counter_val),
    .sec_tick             (sec_tick)
  );

  // NOTE: every combinational output gets a default first so no path through
  // the case statement can leave a value held, which would infer a latch.
  always_comb begin
    phase_d = phase_q;
    sec_d   = sec_q;
    target  = phase_q;
    leave   = 1'b0;
    sec_n   = sec_q + 1'b1;
`ifdef TL_PED_PHASE_EN
    resume_d   = resume_q;
    enter_walk = 1'b0;
`endif
    unique case (phase_q)
      A_GREEN: begin leave = (sec_n >= A_MIN) && traffic_B; target = A_AMBER; end
      A_AMBER: begin leave = (sec_n >= AMB);  target = RED_AB;  end
      RED_AB:  begin leave = (sec_n >= ALLR); target = B_GREEN; end
      B_GREEN: begin
        // Max green wins regardless of demand.
        leave  = (sec_n >= B_MAX) || ((sec_n >= B_MIN) && !traffic_B);
        target = B_AMBER;
      end
      B_AMBER: begin leave = (sec_n >= AMB);  target = RED_BA;  end
      RED_BA:  begin leave = (sec_n >= ALLR); target = A_GREEN; end
`ifdef TL_PED_PHASE_EN
      PED_WALK: begin leave = (sec_n >= PED); target = resume_q; end
`endif
      default: begin leave = 1'b1; target = A_GREEN; end
    endcase

`ifdef TL_PED_PHASE_EN
    // A pending walk request diverts the clearance exit; the green is resumed later.
    if (pend_q && (phase_q == RED_AB || phase_q == RED_BA)) begin
      resume_d = sec_tick && leave ? target : resume_q;
      target   = PED_WALK;
    end
    enter_walk = sec_tick && leave && (target == PED_WALK);
`endif

    if (sec_tick) begin
      if (leave) begin
        phase_d = target;
        sec_d   = '0;
      end else if (phase_q == A_GREEN && sec_n > A_MIN) begin
        sec_d = A_MIN;
      end else begin
        sec_d = sec_n;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= A_GREEN;
      sec_q   <= '0;
    end else begin
      phase_q <= phase_d;
      sec_q   <= sec_d;
    end
  end

`ifdef TL_PED_PHASE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q   <= 1'b0;
      resume_q <= B_GREEN;
    end else begin
      pend_q   <= (pend_q & ~enter_walk) | ped_req;
      resume_q <= resume_d;
    end
  end

  assign walk_light = (phase_q == PED_WALK);
`endif

  assign lamps           = lamp_decode(phase_q);
  assign red_light_A     = lamps.red_a;
  assign amber_light_A   = lamps.amber_a;
  assign green_light_A   = lamps.green_a;
  assign red_light_B     = lamps.red_b;
  assign amber_light_B   = lamps.amber_b;
  assign green_light_B   = lamps.green_b;
  assign sec_counter_val = sec_q;
  assign phase_o         = phase_q;

endmodule

// File: tb/tb_tl_phase_scheduler.sv
// Self-checking bench for tl_phase_scheduler: time-based behavioural model,
// per-cycle compare, directed scenarios and randomized demand. Honours TL_PED_PHASE_EN.
module tb_tl_phase_scheduler;
  import tl_pkg::*;

  localparam int TD    = 6;
  localparam int AMIN  = 20;
  localparam int BMIN  = 5;
  localparam int BMAX  = 15;
  localparam int AMB_S = 3;
  localparam int ALLR  = 1;
  localparam int PED_S = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       traffic_B = 1'b0;
  logic       ra, aa, ga, rb, ab, gb;
  logic [7:0] sec_v;
  logic [3:0] ms_v;
  logic [2:0] ph_v;
`ifdef TL_PED_PHASE_EN
  logic       ped_req = 1'b0;
  logic       walk_light;
`endif

  int errors = 0;
  int checks = 0;
  int t = 0;

  always #5 clk = ~clk;

  tl_phase_scheduler #(
    .TICK_DIV(TD), .A_MIN_GREEN(AMIN), .B_MIN_GREEN(BMIN), .B_MAX_GREEN(BMAX),
`ifdef TL_PED_PHASE_EN
    .PED_T(PED_S),
`endif
    .AMBER_T(AMB_S), .ALL_RED_T(ALLR)
  ) dut (
    .clk(clk), .rst(rst), .traffic_B(traffic_B),
`ifdef TL_PED_PHASE_EN
    .ped_req(ped_req), .walk_light(walk_light),
`endif
    .red_light_A(ra), .amber_light_A(aa), .green_light_A(ga),
    .red_light_B(rb), .amber_light_B(ab), .green_light_B(gb),
    .sec_counter_val(sec_v), .mili_sec_counter_val(ms_v), .phase_o(ph_v)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0d: got %0d expected %0d", name, t, act, exp);
    end
  endtask

  // Required lamp pattern {rA,aA,gA,rB,aB,gB} for each phase.
  function automatic int lamps_for(input phase_e ph);
    case (ph)
      A_GREEN: return 'b001100;
      A_AMBER: return 'b010100;
      B_GREEN: return 'b100001;
      B_AMBER: return 'b100010;
      default: return 'b100100;
    endcase
  endfunction

  always @(posedge clk) t <= rst ? 0 : t + 1;

  // Behavioural model: time spent in a phase measured in cycles; decisions at
  // whole-second boundaries of the free-running cycle count.
  phase_e m_ph = A_GREEN;
  phase_e m_resume = B_GREEN;
  int     m_cyc = 0;
  int     m_in = 0;
  bit     m_pend = 1'b0;
  bit     m_valid = 1'b0;

  always @(posedge clk) begin
    int     secs;
    bit     go;
    phase_e nx;
    if (rst) begin
      m_ph = A_GREEN; m_cyc = 0; m_in = 0; m_pend = 1'b0; m_resume = B_GREEN;
      m_valid = 1'b1;
    end else begin
      go = 1'b0;
      nx = m_ph;
      if (m_cyc % TD == TD - 1) begin
        secs = (m_in + 1) / TD;
        case (m_ph)
          A_GREEN:  begin go = (secs >= AMIN) && traffic_B; nx = A_AMBER; end
          A_AMBER:  begin go = secs >= AMB_S; nx = RED_AB;  end
          RED_AB:   begin go = secs >= ALLR;  nx = B_GREEN; end
          B_GREEN:  begin go = (secs >= BMAX) || (secs >= BMIN && !traffic_B); nx = B_AMBER; end
          B_AMBER:  begin go = secs >= AMB_S; nx = RED_BA;  end
          RED_BA:   begin go = secs >= ALLR;  nx = A_GREEN; end
          PED_WALK: begin go = secs >= PED_S; nx = m_resume; end
          default:  begin go = 1'b1; nx = A_GREEN; end
        endcase
`ifdef TL_PED_PHASE_EN
        if (go && m_pend && (m_ph == RED_AB || m_ph == RED_BA)) begin
          m_resume = nx;
          nx = PED_WALK;
          m_pend = 1'b0;
        end
`endif
      end
`ifdef TL_PED_PHASE_EN
      if (ped_req) m_pend = 1'b1;
`endif
      m_cyc++;
      if (go) begin m_ph = nx; m_in = 0; end
      else m_in++;
    end
  end

  always @(negedge clk) begin
    int exp_sec;
    if (m_valid) begin
      exp_sec = m_in / TD;
      if (m_ph == A_GREEN && exp_sec > AMIN) exp_sec = AMIN;
      check("phase", int'(ph_v), int'(m_ph));
      check("sec", int'(sec_v), exp_sec);
      check("mili", int'(ms_v), m_cyc % TD);
      check("lamps", int'({ra, aa, ga, rb, ab, gb}), lamps_for(m_ph));
      check("one_lamp_a", int'($countones({ra, aa, ga}) <= 1), 1);
      check("one_lamp_b", int'($countones({rb, ab, gb}) <= 1), 1);
      check("no_conflict", int'((ga | aa) & (gb | ab)), 0);
`ifdef TL_PED_PHASE_EN
      check("walk", int'(walk_light), int'(m_ph == PED_WALK));
`endif
    end
  end

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_phase(input phase_e ph, input int budget, input string name, input int exp_t);
    for (int i = 0; i < budget && ph_v != ph; i++) @(negedge clk);
    check({name, "_phase"}, int'(ph_v), int'(ph));
    check({name, "_time"}, t, exp_t);
  endtask

  initial begin
    int hold;
    // 1: idle main road, no side demand
    do_reset(2);
    check("rst_phase", int'(ph_v), int'(A_GREEN));
    check("rst_lamps", int'({ra, aa, ga, rb, ab, gb}), 'b001100);
    check("rst_sec", int'(sec_v), 0);
    check("rst_mili", int'(ms_v), 0);
    repeat (5) @(negedge clk);
    check("mili_top", int'(ms_v), 5);
    @(negedge clk);
    check("mili_wrap", int'(ms_v), 0);
    check("sec_first", int'(sec_v), 1);
    repeat (394) @(negedge clk);
    check("idle_phase", int'(ph_v), int'(A_GREEN));
    check("idle_sec_sat", int'(sec_v), 20);

    // 2: continuous side demand, full cycle with max green
    do_reset(2);
    traffic_B = 1'b1;
    wait_phase(A_AMBER, 200, "t2_a_amber", 120);
    wait_phase(RED_AB, 50, "t2_red_ab", 138);
    wait_phase(B_GREEN, 50, "t2_b_green", 144);
    wait_phase(B_AMBER, 150, "t2_b_amber", 234);
    wait_phase(RED_BA, 50, "t2_red_ba", 252);
    wait_phase(A_GREEN, 50, "t2_a_green", 258);

    // 3: demand drops early in B green, min green ends it
    do_reset(2);
    traffic_B = 1'b1;
    wait_phase(B_GREEN, 200, "t3_b_green", 144);
    for (int i = 0; i < 50 && sec_v != 8'd2; i++) @(negedge clk);
    check("t3_sec2", int'(sec_v), 2);
    traffic_B = 1'b0;
    wait_phase(B_AMBER, 100, "t3_b_amber", 174);

    // 4: reset during B amber
    do_reset(2);
    traffic_B = 1'b1;
    wait_phase(B_AMBER, 300, "t4_b_amber", 234);
    repeat (4) @(negedge clk);
    do_reset(1);
    check("t4_phase", int'(ph_v), int'(A_GREEN));
    check("t4_sec", int'(sec_v), 0);
    check("t4_mili", int'(ms_v), 0);
    check("t4_lamps", int'({ra, aa, ga, rb, ab, gb}), 'b001100);

    // 5: short demand pulse between ticks is ignored
    traffic_B = 1'b0;
    do_reset(2);
    repeat (150) @(negedge clk);
    for (int i = 0; i < 10 && ms_v != 4'd1; i++) @(negedge clk);
    traffic_B = 1'b1;
    repeat (2) @(negedge clk);
    traffic_B = 1'b0;
    repeat (30) @(negedge clk);
    check("t5_phase", int'(ph_v), int'(A_GREEN));
    check("t5_sec", int'(sec_v), 20);

`ifdef TL_PED_PHASE_EN
    // 6: walk request is served after the A->B clearance
    do_reset(2);
    traffic_B = 1'b1;
    repeat (10) @(negedge clk);
    ped_req = 1'b1;
    @(negedge clk);
    ped_req = 1'b0;
    wait_phase(RED_AB, 200, "t6_red_ab", 138);
    wait_phase(PED_WALK, 50, "t6_walk", 144);
    check("t6_walk_light", int'(walk_light), 1);
    check("t6_reds", int'({ra, aa, ga, rb, ab, gb}), 'b100100);
    wait_phase(B_GREEN, 50, "t6_b_green", 168);
`endif

    // Randomized demand with occasional resets
    do_reset(2);
    hold = 0;
    for (int i = 0; i < 5000; i++) begin
      if (hold == 0) begin
        traffic_B = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 80);
      end
      hold--;
      rst = ($urandom_range(0, 1499) == 0);
`ifdef TL_PED_PHASE_EN
      ped_req = ($urandom_range(0, 149) == 0);
`endif
      @(negedge clk);
    end
    rst = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
